digit_serial_mult: RTL and testbench

DIGIT_SERIAL_MULT -- requirements
Module: digit_serial_mult

---
 rtl/digit_serial_mult_pkg.sv | 19 +
 rtl/dsm_pp_unit.sv | 24 ++
 rtl/digit_serial_mult.sv | 155 +++++++++++++++
 tb/tb_digit_serial_mult.sv | 433 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/digit_serial_mult_pkg.sv
// Shared types and sizing helpers for the digit-serial multiplier.
// Imported by the top level and the partial-product unit.
package digit_serial_mult_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_e;

    function automatic int digits(input int max_width, input int p);
        return max_width / p;
    endfunction

    function automatic int acc_width(input int p, input int max_digits);
        return 2 * p + $clog2(max_digits) + 2;
    endfunction

endpackage

// File: rtl/dsm_pp_unit.sv
// Combinational P x P digit product with per-operand signedness,
// sign-extended to the accumulator width.
module dsm_pp_unit #(
    parameter int P     = 2,
    parameter int ACC_W = 10
) (
    input  logic [P-1:0]     i_x,
    input  logic [P-1:0]     i_y,
    input  logic             i_x_signed,
    input  logic             i_y_signed,
    output logic [ACC_W-1:0] o_pp
);

    logic signed [P:0]     w_x;
    logic signed [P:0]     w_y;
    logic signed [2*P+1:0] w_prod;

    // an extra top bit lets one multiplier serve signed and unsigned digits
    assign w_x    = {i_x_signed & i_x[P-1], i_x};
    assign w_y    = {i_y_signed & i_y[P-1], i_y};
    assign w_prod = w_x * w_y;
    assign o_pp   = ACC_W'(w_prod);

endmodule

// File: rtl/digit_serial_mult.sv
// Column-scanning digit-serial multiplier: one partial product per
// cycle, product digits streamed LSB-first over a valid/ready port.
module digit_serial_mult
    import digit_serial_mult_pkg::*;
#(
    parameter int P          = 2,
    parameter int MAX_WIDTH  = 16,
    localparam int MAX_DIGITS = digits(MAX_WIDTH, P),
    localparam int DW         = $clog2(MAX_DIGITS) + 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_in_valid,
    output logic                 o_in_ready,
    input  logic [MAX_WIDTH-1:0] i_a,
    input  logic [MAX_WIDTH-1:0] i_b,
    input  logic [DW-1:0]        i_num_digits,
    input  logic                 i_signed_mode,
    output logic                 o_out_valid,
    input  logic                 i_out_ready,
    output logic [P-1:0]         o_out_digit,
    output logic                 o_out_last,
    output logic                 o_busy
);

    localparam int ACC_W = acc_width(P, MAX_DIGITS);
    localparam int KW    = DW + 1;
    localparam int IW    = (MAX_DIGITS > 1) ? $clog2(MAX_DIGITS) : 1;

    state_e                          r_state;
    logic [MAX_WIDTH-1:0]            r_a;
    logic [MAX_WIDTH-1:0]            r_b;
    logic                            r_signed;
    logic [DW-1:0]                   r_n;
    logic [KW-1:0]                   r_k;
    logic [DW-1:0]                   r_i;
    logic [ACC_W-1:0]                r_acc;

    logic [DW-1:0]                   w_n_in;
    logic [MAX_WIDTH-1:0]            w_mask;
    logic [MAX_DIGITS-1:0][P-1:0]    w_a_dig;
    logic [MAX_DIGITS-1:0][P-1:0]    w_b_dig;
    logic [DW-1:0]                   w_j;
    logic [DW-1:0]                   w_top;
    logic [KW-1:0]                   w_nk;
    logic [DW-1:0]                   w_i_hi;
    logic                            w_col_last;
    logic [KW-1:0]                   w_kmax;
    logic [KW-1:0]                   w_k_nxt;
    logic [DW-1:0]                   w_lo_nxt;
    logic [ACC_W-1:0]                w_pp;
    logic [ACC_W-1:0]                w_sum;
    logic [ACC_W-1:0]                w_shift;
    logic                            w_run_emit;

    always_comb begin
        w_n_in = i_num_digits;
        if (i_num_digits == '0) begin
            w_n_in = DW'(1);
        end else if (i_num_digits > DW'(MAX_DIGITS)) begin
            w_n_in = DW'(MAX_DIGITS);
        end
    end

    always_comb begin
        w_mask = '0;
        for (int d = 0; d < MAX_DIGITS; d++) begin
            w_mask[d*P +: P] = (DW'(d) < w_n_in) ? {P{1'b1}} : {P{1'b0}};
        end
    end

    assign w_a_dig = r_a;
    assign w_b_dig = r_b;
    assign w_j     = DW'(r_k - KW'(r_i));
    assign w_top   = r_n - DW'(1);
    assign w_nk    = KW'(r_n);

    // column k holds rows max(0,k-N+1)..min(k,N-1)
    assign w_i_hi     = (r_k < w_nk - KW'(1)) ? DW'(r_k) : w_top;
    assign w_col_last = (r_i == w_i_hi);
    assign w_kmax     = {r_n, 1'b0} - KW'(2);
    assign w_k_nxt    = r_k + KW'(1);
    assign w_lo_nxt   = (w_k_nxt >= w_nk) ?
                        DW'(w_k_nxt - w_nk + KW'(1)) : '0;

    dsm_pp_unit #(
        .P     (P),
        .ACC_W (ACC_W)
    ) u_pp (
        .i_x        (w_a_dig[r_i[IW-1:0]]),
        .i_y        (w_b_dig[w_j[IW-1:0]]),
        .i_x_signed (r_signed && (r_i == w_top)),
        .i_y_signed (r_signed && (w_j == w_top)),
        .o_pp       (w_pp)
    );

    assign w_sum   = r_acc + w_pp;
    assign w_shift = {{P{r_signed & w_sum[ACC_W-1]}}, w_sum[ACC_W-1:P]};

    assign w_run_emit  = (r_state == RUN) && w_col_last;
    assign o_in_ready  = (r_state == IDLE);
    assign o_busy      = (r_state != IDLE);
    assign o_out_valid = w_run_emit || (r_state == FLUSH);
    assign o_out_last  = (r_state == FLUSH);
    assign o_out_digit = (r_state == FLUSH) ? r_acc[P-1:0] :
                         w_run_emit ? w_sum[P-1:0] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_signed <= 1'b0;
            r_n      <= '0;
            r_k      <= '0;
            r_i      <= '0;
            r_acc    <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (i_in_valid) begin
                        r_a      <= i_a & w_mask;
                        r_b      <= i_b & w_mask;
                        r_signed <= i_signed_mode;
                        r_n      <= w_n_in;
                        r_k      <= '0;
                        r_i      <= '0;
                        r_acc    <= '0;
                        r_state  <= RUN;
                    end
                end
                RUN: begin
                    if (!w_col_last) begin
                        r_acc <= w_sum;
                        r_i   <= r_i + DW'(1);
                    end else if (i_out_ready) begin
                        r_acc <= w_shift;
                        r_k   <= w_k_nxt;
                        r_i   <= w_lo_nxt;
                        if (r_k == w_kmax) begin
                            r_state <= FLUSH;
                        end
                    end
                end
                FLUSH: begin
                    if (i_out_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_digit_serial_mult.sv
// Randomised and directed bench for digit_serial_mult at P=2 and P=4,
// against a plain-arithmetic product model.
module tb_digit_serial_mult;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int          sel = 2;
    logic        tb_valid = 1'b0;
    logic        tb_ordy = 1'b1;
    logic        tb_sgn = 1'b0;
    logic [15:0] tb_a = '0;
    logic [15:0] tb_b = '0;
    logic [7:0]  tb_nd = '0;

    logic       ir2, ov2, ol2, bz2;
    logic [1:0] od2;
    logic       ir4, ov4, ol4, bz4;
    logic [3:0] od4;

    logic       w_ir, w_ov, w_ol, w_bz;
    logic [7:0] w_od;

    assign w_ir = (sel == 4) ? ir4 : ir2;
    assign w_ov = (sel == 4) ? ov4 : ov2;
    assign w_ol = (sel == 4) ? ol4 : ol2;
    assign w_bz = (sel == 4) ? bz4 : bz2;
    assign w_od = (sel == 4) ? {4'b0, od4} : {6'b0, od2};

    digit_serial_mult #(.P(2), .MAX_WIDTH(16)) u_dut2 (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_in_valid    (tb_valid && sel == 2),
        .o_in_ready    (ir2),
        .i_a           (tb_a),
        .i_b           (tb_b),
        .i_num_digits  (tb_nd[3:0]),
        .i_signed_mode (tb_sgn),
        .o_out_valid   (ov2),
        .i_out_ready   (tb_ordy),
        .o_out_digit   (od2),
        .o_out_last    (ol2),
        .o_busy        (bz2)
    );

    digit_serial_mult #(.P(4), .MAX_WIDTH(16)) u_dut4 (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_in_valid    (tb_valid && sel == 4),
        .o_in_ready    (ir4),
        .i_a           (tb_a),
        .i_b           (tb_b),
        .i_num_digits  (tb_nd[2:0]),
        .i_signed_mode (tb_sgn),
        .o_out_valid   (ov4),
        .i_out_ready   (tb_ordy),
        .o_out_digit   (od4),
        .o_out_last    (ol4),
        .o_busy        (bz4)
    );

    int nvec = 0;
    int nerr = 0;

    logic [7:0] got[$];
    bit         lastq[$];
    logic [7:0] held[$];

    int ncyc, wcyc;
    bit to, rdy_after;

    function automatic int eff_n(input int nd, input int md);
        return (nd == 0) ? 1 : ((nd > md) ? md : nd);
    endfunction

    // reference: exact product of the N*P-bit operands, then pick digit d
    function automatic logic [7:0] exp_digit(input int p, input int md,
                                             input logic [15:0] a,
                                             input logic [15:0] b,
                                             input int nd, input bit sg,
                                             input int d);
        int     n, w;
        longint am, bm, prod, msk;
        n    = eff_n(nd, md);
        w    = n * p;
        msk  = (longint'(1) << w) - 1;
        am   = longint'(a) & msk;
        bm   = longint'(b) & msk;
        if (sg && am[w-1]) am = am - (longint'(1) << w);
        if (sg && bm[w-1]) bm = bm - (longint'(1) << w);
        prod = am * bm;
        return 8'((prod >> (d * p)) & ((longint'(1) << p) - 1));
    endfunction

    task automatic run_op(input int s, input logic [15:0] av,
                          input logic [15:0] bv, input int nd,
                          input bit sg, input int stall_d,
                          input int stall_n);
        bit         hs, l;
        logic [7:0] d;
        int         stalled;
        got.delete();
        lastq.delete();
        held.delete();
        sel       = s;
        to        = 1'b1;
        ncyc      = 0;
        wcyc      = 0;
        stalled   = 0;
        tb_ordy   = 1'b1;
        @(negedge clk);
        while (!w_ir && wcyc < 100) begin
            @(negedge clk);
            wcyc++;
        end
        tb_a     = av;
        tb_b     = bv;
        tb_nd    = 8'(nd);
        tb_sgn   = sg;
        tb_valid = 1'b1;
        @(posedge clk);
        #1;
        tb_valid  = 1'b0;
        rdy_after = w_ir;
        tb_a      = 16'($urandom);
        tb_b      = 16'($urandom);
        tb_nd     = 8'($urandom_range(0, 7));
        tb_sgn    = 1'($urandom);
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            tb_ordy = 1'b1;
            if (w_ov && got.size() == stall_d && stalled < stall_n) begin
                tb_ordy = 1'b0;
                held.push_back(w_od);
                stalled++;
            end
            #1;
            hs = w_ov && tb_ordy;
            d  = w_od;
            l  = w_ol;
            @(posedge clk);
            ncyc++;
            if (hs) begin
                got.push_back(d);
                lastq.push_back(l);
                if (l) begin
                    to = 1'b0;
                    break;
                end
            end
        end
        tb_ordy = 1'b1;
    endtask

    task automatic test_reset();
        logic [11:0] obs;
        rst_n = 1'b0;
        for (int s = 2; s <= 4; s += 2) begin
            sel = s;
            #1;
            obs = {w_ir, w_ov, w_ol, w_bz, w_od};
            nvec++;
            if (obs !== {1'b1, 1'b0, 1'b0, 1'b0, 8'h00}) begin
                nerr++;
                $display("FAIL reset_p%0d got %h expected %h", s, obs,
                         {1'b1, 11'h0});
            end
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_n1_unsigned();
        logic [7:0] e[2] = '{8'h1, 8'h2};
        run_op(2, 16'd3, 16'd3, 1, 1'b0, -1, 0);
        nvec++;
        if (to || got.size() != 2) begin
            nerr++;
            $display("FAIL n1_count got %0d digits expected 2", got.size());
        end
        for (int i = 0; i < 2; i++) begin
            nvec++;
            if (got[i] !== e[i]) begin
                nerr++;
                $display("FAIL n1_digit%0d got %h expected %h", i, got[i], e[i]);
            end
        end
        nvec++;
        if (lastq[0] !== 1'b0 || lastq[1] !== 1'b1) begin
            nerr++;
            $display("FAIL n1_last got %b%b expected 01", lastq[0], lastq[1]);
        end
        nvec++;
        if (ncyc != 2) begin
            nerr++;
            $display("FAIL n1_cycles got %0d expected 2", ncyc);
        end
    endtask

    task automatic test_signed_n2();
        logic [7:0] e[4] = '{8'h1, 8'h0, 8'h3, 8'h3};
        run_op(2, 16'hFFFD, 16'h0005, 2, 1'b1, -1, 0);
        nvec++;
        if (to || got.size() != 4) begin
            nerr++;
            $display("FAIL sn2_count got %0d digits expected 4", got.size());
        end
        for (int i = 0; i < 4; i++) begin
            nvec++;
            if (got[i] !== e[i]) begin
                nerr++;
                $display("FAIL sn2_digit%0d got %h expected %h", i, got[i], e[i]);
            end
        end
    endtask

    task automatic test_full_unsigned();
        logic [7:0] e[8] = '{8'h1, 8'h0, 8'h0, 8'h0, 8'hE, 8'hF, 8'hF, 8'hF};
        run_op(4, 16'hFFFF, 16'hFFFF, 4, 1'b0, -1, 0);
        nvec++;
        if (to || got.size() != 8) begin
            nerr++;
            $display("FAIL full_count got %0d digits expected 8", got.size());
        end
        for (int i = 0; i < 8; i++) begin
            nvec++;
            if (got[i] !== e[i]) begin
                nerr++;
                $display("FAIL full_digit%0d got %h expected %h", i, got[i], e[i]);
            end
        end
        nvec++;
        if (ncyc != 17) begin
            nerr++;
            $display("FAIL full_cycles got %0d expected 17", ncyc);
        end
    endtask

    task automatic test_stall();
        logic [7:0] e[8] = '{8'h1, 8'h0, 8'h0, 8'h0, 8'hE, 8'hF, 8'hF, 8'hF};
        run_op(4, 16'hFFFF, 16'hFFFF, 4, 1'b0, 2, 3);
        for (int i = 0; i < 8; i++) begin
            nvec++;
            if (got[i] !== e[i]) begin
                nerr++;
                $display("FAIL stall_digit%0d got %h expected %h", i, got[i], e[i]);
            end
        end
        nvec++;
        if (held.size() != 3) begin
            nerr++;
            $display("FAIL stall_held_count got %0d expected 3", held.size());
        end
        foreach (held[i]) begin
            nvec++;
            if (held[i] !== 8'h0) begin
                nerr++;
                $display("FAIL stall_hold%0d got %h expected 00", i, held[i]);
            end
        end
        nvec++;
        if (ncyc != 20) begin
            nerr++;
            $display("FAIL stall_cycles got %0d expected 20", ncyc);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] a0, b0, a1, b1;
        bit          s0, s1;
        a0 = 16'($urandom);
        b0 = 16'($urandom);
        s0 = 1'($urandom);
        run_op(4, a0, b0, 0, s0, -1, 0);
        nvec++;
        if (to || got.size() != 2) begin
            nerr++;
            $display("FAIL b2b_n0_count got %0d expected 2", got.size());
        end
        for (int i = 0; i < 2; i++) begin
            nvec++;
            if (got[i] !== exp_digit(4, 4, a0, b0, 0, s0, i)) begin
                nerr++;
                $display("FAIL b2b_n0_digit%0d got %h expected %h", i, got[i],
                         exp_digit(4, 4, a0, b0, 0, s0, i));
            end
        end
        nvec++;
        if (rdy_after !== 1'b0) begin
            nerr++;
            $display("FAIL b2b_ready_drop got %b expected 0", rdy_after);
        end
        a1 = 16'($urandom);
        b1 = 16'($urandom);
        s1 = 1'($urandom);
        run_op(4, a1, b1, 5, s1, -1, 0);
        nvec++;
        if (wcyc != 0) begin
            nerr++;
            $display("FAIL b2b_ready_gap got %0d waits expected 0", wcyc);
        end
        nvec++;
        if (to || got.size() != 8) begin
            nerr++;
            $display("FAIL b2b_n5_count got %0d expected 8", got.size());
        end
        for (int i = 0; i < 8; i++) begin
            nvec++;
            if (got[i] !== exp_digit(4, 4, a1, b1, 5, s1, i)) begin
                nerr++;
                $display("FAIL b2b_n5_digit%0d got %h expected %h", i, got[i],
                         exp_digit(4, 4, a1, b1, 5, s1, i));
            end
        end
    endtask

    task automatic test_reset_mid_run();
        logic [11:0] obs;
        logic [15:0] a, b;
        int          bad;
        sel = 4;
        @(negedge clk);
        tb_a     = 16'($urandom);
        tb_b     = 16'($urandom);
        tb_nd    = 8'd4;
        tb_sgn   = 1'b1;
        tb_valid = 1'b1;
        @(posedge clk);
        #1;
        tb_valid = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        obs = {w_ir, w_ov, w_ol, w_bz, w_od};
        nvec++;
        if (obs !== {1'b1, 11'h0}) begin
            nerr++;
            $display("FAIL midreset_outputs got %h expected %h", obs, {1'b1, 11'h0});
        end
        @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        repeat (30) begin
            @(negedge clk);
            if (w_ov || w_bz) bad++;
        end
        nvec++;
        if (bad != 0) begin
            nerr++;
            $display("FAIL midreset_residual got %0d active cycles expected 0", bad);
        end
        a = 16'($urandom);
        b = 16'($urandom);
        run_op(4, a, b, 4, 1'b1, -1, 0);
        nvec++;
        if (to || got.size() != 8) begin
            nerr++;
            $display("FAIL midreset_count got %0d expected 8", got.size());
        end
        for (int i = 0; i < 8; i++) begin
            nvec++;
            if (got[i] !== exp_digit(4, 4, a, b, 4, 1'b1, i)) begin
                nerr++;
                $display("FAIL midreset_digit%0d got %h expected %h", i, got[i],
                         exp_digit(4, 4, a, b, 4, 1'b1, i));
            end
        end
    endtask

    task automatic test_random();
        int          s, md, nd, n, sd, sn, nl;
        bit          sg;
        logic [15:0] a, b;
        logic [7:0]  e;
        for (int v = 0; v < 40; v++) begin
            s  = ($urandom_range(0, 1) == 0) ? 2 : 4;
            md = (s == 2) ? 8 : 4;
            nd = $urandom_range(0, (s == 2) ? 15 : 7);
            n  = eff_n(nd, md);
            sg = 1'($urandom);
            a  = 16'($urandom);
            b  = 16'($urandom);
            sd = $urandom_range(0, 2 * n - 1);
            sn = $urandom_range(0, 2);
            run_op(s, a, b, nd, sg, sd, sn);
            nvec++;
            if (to || got.size() != 2 * n) begin
                nerr++;
                $display("FAIL rnd%0d_count got %0d expected %0d", v,
                         got.size(), 2 * n);
            end
            for (int i = 0; i < 2 * n; i++) begin
                e = exp_digit(s, md, a, b, nd, sg, i);
                nvec++;
                if (got[i] !== e) begin
                    nerr++;
                    $display("FAIL rnd%0d_digit%0d got %h expected %h", v, i,
                             got[i], e);
                end
            end
            nl = 0;
            foreach (lastq[i]) if (lastq[i]) nl++;
            nvec++;
            if (nl != 1 || lastq[2*n-1] !== 1'b1) begin
                nerr++;
                $display("FAIL rnd%0d_last got %0d flags expected 1 on final", v, nl);
            end
            foreach (held[i]) begin
                nvec++;
                if (held[i] !== got[sd]) begin
                    nerr++;
                    $display("FAIL rnd%0d_hold%0d got %h expected %h", v, i,
                             held[i], got[sd]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_n1_unsigned();
        test_signed_n2();
        test_full_unsigned();
        test_stall();
        test_back_to_back();
        test_reset_mid_run();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
